// File: rtl/memory_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of a single
// four-phase main-memory port, with per-transaction ack timeout.
module memory_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_ack,
    output logic [WIDTH-1:0]      i_rdata,
    output logic                  i_err,
    input  logic                  d_enable,
    input  logic                  d_rw,
    input  logic [3:0]            d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0]      d_wdata,
    output logic                  d_ack,
    output logic [WIDTH-1:0]      d_rdata,
    output logic                  d_err,
    output logic                  mem_enable,
    output logic                  mem_rw,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMAX = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE, DONE} state_t;

    state_t                  state_q;
    logic                    last_d_q;   // 1: data port won the most recent grant
    logic [CW-1:0]           cnt_q;
    logic                    mem_en_q;
    logic                    mem_rw_q;
    logic [3:0]              mem_be_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [WIDTH-1:0]        mem_wdata_q;
    logic                    i_ack_q, i_err_q, d_ack_q, d_err_q;
    logic [WIDTH-1:0]        i_rdata_q, d_rdata_q;
    logic                    busy_q;
    logic                    pick_d;
    logic                    owner_en;

    // On a tie the port that did not win last time is served.
    assign pick_d   = d_enable & (~i_enable | ~last_d_q);
    assign owner_en = last_d_q ? d_enable : i_enable;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b1;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!mem_ack && (i_enable || d_enable)) begin
                        last_d_q <= pick_d;
                        if (pick_d) begin
                            mem_rw_q    <= d_rw;
                            mem_be_q    <= d_be;
                            mem_addr_q  <= d_addr;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            mem_rw_q    <= 1'b1;
                            mem_be_q    <= '1;
                            mem_addr_q  <= i_addr;
                            mem_wdata_q <= '0;
                        end
                        mem_en_q <= 1'b1;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        if (mem_rw_q) begin
                            if (last_d_q) d_rdata_q <= mem_rdata;
                            else          i_rdata_q <= mem_rdata;
                        end
                        mem_en_q <= 1'b0;
                        state_q  <= RELEASE;
                    end else if (cnt_q == TMAX) begin
                        // Timeout skips RELEASE: memory never acked, so there is nothing to wait out.
                        mem_en_q <= 1'b0;
                        state_q  <= DONE;
                        if (last_d_q) begin
                            d_err_q   <= 1'b1;
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= '0;
                        end else begin
                            i_err_q   <= 1'b1;
                            i_ack_q   <= 1'b1;
                            i_rdata_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!mem_ack) begin
                        state_q <= DONE;
                        if (last_d_q) d_ack_q <= 1'b1;
                        else          i_ack_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (!owner_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        i_ack_q <= 1'b0;
                        i_err_q <= 1'b0;
                        d_ack_q <= 1'b0;
                        d_err_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_ack      = i_ack_q;
    assign i_err      = i_err_q;
    assign i_rdata    = i_rdata_q;
    assign d_ack      = d_ack_q;
    assign d_err      = d_err_q;
    assign d_rdata    = d_rdata_q;
    assign mem_enable = mem_en_q;
    assign mem_rw     = mem_rw_q;
    assign mem_be     = mem_be_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: single-port reads/writes, round-robin
// ties, ack timeout, mid-transaction reset and early enable drop.
module tb_memory_arbiter;

    logic        clk;
    logic        reset;
    logic        i_enable;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_enable;
    logic        d_rw;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_enable;
    logic        mem_rw;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    memory_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_enable(i_enable), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_enable(d_enable), .d_rw(d_rw), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Waits (bounded) for a grant, then checks the granted port and completes
    // the transaction, dropping the winner's enable on ack and optionally re-raising it.
    task automatic serve(input logic exp_d, input logic [31:0] rd, input logic rearm);
        int n;
        n = 0;
        step();
        while (!mem_enable && n < 20) begin
            step();
            n++;
        end
        chk("rr_grant_seen", mem_enable, 1'b1);
        chk("rr_grant_addr", mem_addr, exp_d ? 32'h200 : 32'h100);
        mem_ack = 1'b1; mem_rdata = rd;
        step();
        chk("rr_release_en", mem_enable, 1'b0);
        mem_ack = 1'b0;
        step();
        chk("rr_win_ack", exp_d ? d_ack : i_ack, 1'b1);
        chk("rr_lose_ack", exp_d ? i_ack : d_ack, 1'b0);
        chk("rr_rdata", exp_d ? d_rdata : i_rdata, rd);
        if (exp_d) d_enable = 1'b0; else i_enable = 1'b0;
        step();
        chk("rr_idle_busy", busy, 1'b0);
        if (rearm) begin
            if (exp_d) d_enable = 1'b1; else i_enable = 1'b1;
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; i_enable = 1'b0; i_addr = '0;
        d_enable = 1'b0; d_rw = 1'b1; d_be = '0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        step(); step();

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_enable, 1'b0);
        chk("rst_mem_rw", mem_rw, 1'b1);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", mem_be, 4'h0);
        chk("rst_acks", {i_ack, d_ack, i_err, d_err}, 4'h0);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        reset = 1'b1;

        // I-only read at 0x4, ack after 5 enable cycles
        i_enable = 1'b1; i_addr = 32'h4;
        step();
        chk("i_mem_en", mem_enable, 1'b1);
        chk("i_mem_addr", mem_addr, 32'h4);
        chk("i_mem_rw_be", {mem_rw, mem_be}, 5'h1F);
        chk("i_busy", busy, 1'b1);
        step(); step(); step(); step();
        chk("i_mem_en_hold", mem_enable, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        chk("i_rel_en", mem_enable, 1'b0);
        chk("i_rdata", i_rdata, 32'hDEADBEEF);
        chk("i_ack_early", i_ack, 1'b0);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        step();
        chk("i_ack", i_ack, 1'b1);
        chk("i_d_ack", d_ack, 1'b0);
        chk("i_err", i_err, 1'b0);
        i_enable = 1'b0;
        step();
        chk("i_ack_drop", i_ack, 1'b0);
        chk("i_rdata_hold", i_rdata, 32'hDEADBEEF);
        chk("i_idle", busy, 1'b0);

        // D write at 0x8, be=0010
        d_enable = 1'b1; d_rw = 1'b0; d_be = 4'b0010; d_addr = 32'h8; d_wdata = 32'h11223344;
        step();
        chk("d_mem_en", mem_enable, 1'b1);
        chk("d_mem_rw", mem_rw, 1'b0);
        chk("d_mem_be", mem_be, 4'b0010);
        chk("d_mem_wdata", mem_wdata, 32'h11223344);
        chk("d_mem_addr", mem_addr, 32'h8);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        step();
        chk("d_ack", d_ack, 1'b1);
        chk("d_i_ack", i_ack, 1'b0);
        chk("d_rdata_unch", d_rdata, 32'h0);
        d_enable = 1'b0;
        step();
        chk("d_ack_drop", d_ack, 1'b0);

        // Round-robin: reset, then I and D raised together
        reset = 1'b0;
        step();
        chk("rr_rst_rdata", i_rdata, 32'h0);
        reset = 1'b1;
        i_addr = 32'h100; d_addr = 32'h200; d_rw = 1'b1; d_be = 4'hF;
        i_enable = 1'b1; d_enable = 1'b1;
        serve(1'b0, 32'hA0, 1'b1);
        serve(1'b1, 32'hA1, 1'b1);
        serve(1'b0, 32'hA2, 1'b1);
        serve(1'b1, 32'hA3, 1'b1);
        serve(1'b0, 32'hA4, 1'b0);
        serve(1'b1, 32'hA5, 1'b0);

        // Timeout on a D read (TIMEOUT=8)
        d_enable = 1'b1; d_rw = 1'b1; d_addr = 32'h300;
        step();
        n = 0;
        while (mem_enable && n < 20) begin
            n++;
            step();
        end
        chk("to_cycles", n, 8);
        chk("to_d_err", d_err, 1'b1);
        chk("to_d_ack", d_ack, 1'b1);
        chk("to_d_rdata", d_rdata, 32'h0);
        chk("to_i_ack", i_ack, 1'b0);
        d_enable = 1'b0;
        step();
        chk("to_clear", {d_err, d_ack, busy}, 3'b000);

        // Reset while BUSY, mem_ack held high afterwards
        i_enable = 1'b1; i_addr = 32'h400;
        step();
        chk("rb_busy", {busy, mem_enable}, 2'b11);
        reset = 1'b0; mem_ack = 1'b1;
        step();
        chk("rb_abandon", {mem_enable, busy, i_ack, d_ack}, 4'b0000);
        reset = 1'b1;
        step(); step(); step();
        chk("rb_no_grant", {mem_enable, busy}, 2'b00);
        mem_ack = 1'b0;
        step();
        chk("rb_grant", mem_enable, 1'b1);
        chk("rb_addr", mem_addr, 32'h400);

        // Requester drops enable before DONE: one-cycle ack pulse
        mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A; i_enable = 1'b0;
        step();
        mem_ack = 1'b0;
        step();
        chk("ed_ack_pulse", i_ack, 1'b1);
        chk("ed_rdata", i_rdata, 32'h5A5A5A5A);
        step();
        chk("ed_ack_end", {i_ack, busy}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
